chroma_block_feeder: RTL and testbench
======================================

Name: chroma_block_feeder

Overview:
- Transmitter side of the chroma PE input interface (Vin / InData / horVer / ME_MCBi / filterSel_1 / filterSel_2 / modAddr_IN).
- On a start command, reads a rectangular chroma reference block from a synchronous sample memory in raster order and streams one sample per cycle to ProcessingElement_chroma.
- Mode and filter controls are held stable for the whole block.
- Replaces the behavioural data maker when the PE is integrated into the filter datapath.

Parameters:
- DATA_W, 8, sample width (InData, mem_data).
- ADDR_W, 12, sample memory address width.
- DIM_W, 6, width of block dimension fields and of modAddr_IN.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle command; sampled only in IDLE.
- base_addr  in  ADDR_W  address of the block's top-left sample.
- stride  in  ADDR_W  address distance between rows.
- blk_w_m1  in  DIM_W  samples per row minus 1.
- blk_h_m1  in  DIM_W  rows minus 1.
- cfg_horVer  in  1  filter direction, latched at start.
- cfg_ME_MCBi  in  1  ME/MC-bipred mode, latched at start.
- cfg_fsel1  in  3  first filter select, latched at start.
- cfg_fsel2  in  3  second filter select, latched at start.
- hold  in  1  downstream pause request.
- mem_rd  out  1  memory read strobe.
- mem_addr  out  ADDR_W  memory read address.
- mem_data  in  DATA_W  read data, valid the cycle after mem_rd.
- Vin  out  1  InData valid.
- InData  out  DATA_W  sample to PE.
- horVer  out  1  latched cfg_horVer.
- ME_MCBi  out  1  latched cfg_ME_MCBi.
- filterSel_1  out  3  latched cfg_fsel1.
- filterSel_2  out  3  latched cfg_fsel2.
- modAddr_IN  out  DIM_W  row index of the sample on InData.
- busy  out  1  high from the cycle after start until done.
- done  out  1  one-cycle pulse, block complete.

Behaviour:
- Reset: every output is 0 (including InData, modAddr_IN, latched controls). State is IDLE. Counters are cleared. Reset mid-block aborts immediately and produces no done.
- States: IDLE, FETCH, DRAIN, DONE.
- IDLE:
  - start=1 latches base, stride, dimensions and the cfg_* fields; next state FETCH; busy=1 from the next cycle.
  - start in any other state is ignored.
- FETCH:
  - mem_rd = !hold.
  - mem_addr = row_base + col, computed incrementally with an adder, not a multiplier. row_base starts at base_addr and advances by stride at each row end. All address arithmetic is modulo 2^ADDR_W (wrap allowed).
  - Each issued read advances col. When col == blk_w_m1, col returns to 0 and row increments.
  - After issuing the read for (blk_h_m1, blk_w_m1), next state DRAIN.
- Read pipeline:
  - Cycle t: mem_rd.
  - Cycle t+1: mem_data valid; registered into InData.
  - From edge t+2: Vin=1 with InData and modAddr_IN = row of that read. Row is carried in a 2-stage shadow pipeline.
  - Vin=0 in cycles with no sample; InData holds its last value.
- hold:
  - Gates new reads combinationally.
  - Already-issued reads still complete: at most 2 Vin pulses after hold rises.
  - No sample is lost or duplicated. Resuming continues at the exact next address.
- DRAIN: waits until the pipeline is empty (last Vin emitted), then DONE.
- DONE:
  - done=1 for one cycle, busy=0 in the same cycle, then IDLE.
  - A start in the DONE cycle is ignored.
  - A start the cycle after DONE is accepted.
- Controls: horVer, ME_MCBi, filterSel_1 and filterSel_2 change only on start acceptance and remain stable through DONE and beyond.
- Throughput and latency:
  - 1 sample/cycle without hold.
  - start accepted at edge k: first mem_rd in cycle k+1, first Vin at edge k+3.
  - Total samples = (blk_w_m1+1)*(blk_h_m1+1).
- Degenerate block (blk_w_m1 = blk_h_m1 = 0): exactly one read, one Vin, then done.

Test Plan:
- Reset mid-FETCH with a 4x4 block → all outputs 0 within the same cycle, no done; a later start runs normally.
- base=0x010, stride=0x020, blk_w_m1=3, blk_h_m1=2, memory holds addr[7:0] → 12 Vin pulses in consecutive cycles; InData = 10,11,12,13,30,31,32,33,50,51,52,53; modAddr_IN = 0×4, 1×4, 2×4; first Vin 3 cycles after start; done 1 cycle after the last Vin.
- Same block with hold high for 5 cycles starting mid row 1 → ≤2 Vin while hold is high, then the sequence resumes with no gap or duplicate; still 12 samples total.
- base=0xFFE, stride=0x004, blk_w_m1=3, blk_h_m1=0 → mem_addr = FFE, FFF, 000, 001.
- 1x1 block with cfg_fsel1=5, cfg_fsel2=2, cfg_horVer=1 → one Vin; filterSel_1=5, filterSel_2=2, horVer=1 from start to the next start; a start pulse while busy is ignored.

Source files
------------

// File: rtl/chroma_block_feeder.sv
// chroma_block_feeder: streams a rectangular chroma block from sync memory to the PE, one sample/cycle.
module chroma_block_feeder #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 12,
  parameter int DIM_W  = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] stride,
  input  logic [DIM_W-1:0]  blk_w_m1,
  input  logic [DIM_W-1:0]  blk_h_m1,
  input  logic              cfg_horVer,
  input  logic              cfg_ME_MCBi,
  input  logic [2:0]        cfg_fsel1,
  input  logic [2:0]        cfg_fsel2,
  input  logic              hold,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  output logic              Vin,
  output logic [DATA_W-1:0] InData,
  output logic              horVer,
  output logic              ME_MCBi,
  output logic [2:0]        filterSel_1,
  output logic [2:0]        filterSel_2,
  output logic [DIM_W-1:0]  modAddr_IN,
  output logic              busy,
  output logic              done
);
  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;
  state_t state_q, state_d;
  logic [ADDR_W-1:0] row_base_q, row_base_d, stride_q;
  logic [DIM_W-1:0]  col_q, col_d, row_q, row_d, w_q, h_q, r1_q, mod_q;
  logic [DATA_W-1:0] data_q;
  logic [2:0]        fsel1_q, fsel2_q;
  logic              hv_q, me_q, v1_q, vin_q, accept, last_col;
  assign accept      = state_q == IDLE && start;
  assign mem_rd      = state_q == FETCH && !hold;
  assign last_col    = col_q == w_q;
  assign mem_addr    = row_base_q + ADDR_W'(col_q);
  assign busy        = state_q == FETCH || state_q == DRAIN;
  assign done        = state_q == DONE;
  assign Vin         = vin_q;
  assign InData      = data_q;
  assign modAddr_IN  = mod_q;
  assign horVer      = hv_q;
  assign ME_MCBi     = me_q;
  assign filterSel_1 = fsel1_q;
  assign filterSel_2 = fsel2_q;
  always_comb begin
    state_d    = state_q;
    row_base_d = row_base_q;
    col_d      = col_q;
    row_d      = row_q;
    if (accept) begin
      state_d    = FETCH;
      row_base_d = base_addr;
      col_d      = '0;
      row_d      = '0;
    end
    if (mem_rd) begin
      col_d      = last_col ? '0 : col_q + DIM_W'(1);
      row_d      = last_col ? row_q + DIM_W'(1) : row_q;
      row_base_d = last_col ? row_base_q + stride_q : row_base_q;
      state_d    = last_col && row_q == h_q ? DRAIN : FETCH;
    end
    // v1_q clear means the final read has already reached the output register
    if (state_q == DRAIN && !v1_q) state_d = DONE;
    if (state_q == DONE) state_d = IDLE;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      row_base_q <= '0;
      stride_q   <= '0;
      col_q      <= '0;
      row_q      <= '0;
      w_q        <= '0;
      h_q        <= '0;
      hv_q       <= 1'b0;
      me_q       <= 1'b0;
      fsel1_q    <= '0;
      fsel2_q    <= '0;
      v1_q       <= 1'b0;
      r1_q       <= '0;
      vin_q      <= 1'b0;
      data_q     <= '0;
      mod_q      <= '0;
    end else begin
      state_q    <= state_d;
      row_base_q <= row_base_d;
      col_q      <= col_d;
      row_q      <= row_d;
      if (accept) begin
        stride_q <= stride;
        w_q      <= blk_w_m1;
        h_q      <= blk_h_m1;
        hv_q     <= cfg_horVer;
        me_q     <= cfg_ME_MCBi;
        fsel1_q  <= cfg_fsel1;
        fsel2_q  <= cfg_fsel2;
      end
      v1_q  <= mem_rd;
      vin_q <= v1_q;
      if (mem_rd) r1_q <= row_q;
      if (v1_q) begin
        data_q <= mem_data;
        mod_q  <= r1_q;
      end
    end
  end
endmodule

// File: tb/tb_chroma_block_feeder.sv
// tb_chroma_block_feeder: directed vector bench for the chroma block feeder.
module tb_chroma_block_feeder;
  logic        clk = 0, reset = 1, start = 0, hold = 0;
  logic [11:0] base_addr = 0, stride = 0, mem_addr;
  logic [5:0]  blk_w_m1 = 0, blk_h_m1 = 0, modAddr_IN;
  logic        cfg_horVer = 0, cfg_ME_MCBi = 0;
  logic [2:0]  cfg_fsel1 = 0, cfg_fsel2 = 0, filterSel_1, filterSel_2;
  logic        mem_rd, Vin, horVer, ME_MCBi, busy, done;
  logic [7:0]  mem_data = 0, InData;

  chroma_block_feeder dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .stride(stride),
    .blk_w_m1(blk_w_m1), .blk_h_m1(blk_h_m1), .cfg_horVer(cfg_horVer), .cfg_ME_MCBi(cfg_ME_MCBi),
    .cfg_fsel1(cfg_fsel1), .cfg_fsel2(cfg_fsel2), .hold(hold), .mem_rd(mem_rd), .mem_addr(mem_addr),
    .mem_data(mem_data), .Vin(Vin), .InData(InData), .horVer(horVer), .ME_MCBi(ME_MCBi),
    .filterSel_1(filterSel_1), .filterSel_2(filterSel_2), .modAddr_IN(modAddr_IN),
    .busy(busy), .done(done));

  always #5 clk = ~clk;

  // memory content is the low address byte
  always @(posedge clk) if (mem_rd) mem_data <= mem_addr[7:0];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0]  dq[$];
  logic [5:0]  rq[$];
  logic [11:0] aq[$];
  int          cq[$];
  int          done_cnt = 0, done_cyc = 0;
  logic        done_busy = 0;

  always begin
    @(negedge clk);
    #1;
    if (Vin) begin dq.push_back(InData); rq.push_back(modAddr_IN); cq.push_back(cyc); end
    if (mem_rd) aq.push_back(mem_addr);
    if (done) begin done_cnt++; done_cyc = cyc; done_busy = busy; end
  end

  int vecs = 0, errs = 0, s = 0;

  task automatic chk(string name, int act, int exp);
    vecs++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic clear_q();
    dq.delete(); rq.delete(); aq.delete(); cq.delete();
  endtask

  task automatic start_blk(logic [11:0] b, logic [11:0] st, logic [5:0] w, logic [5:0] h,
                           logic hv, logic me, logic [2:0] f1, logic [2:0] f2);
    @(negedge clk);
    base_addr = b; stride = st; blk_w_m1 = w; blk_h_m1 = h;
    cfg_horVer = hv; cfg_ME_MCBi = me; cfg_fsel1 = f1; cfg_fsel2 = f2;
    start = 1;
    s = cyc;
    @(negedge clk);
    start = 0;
  endtask

  task automatic wait_done(string tag);
    int d0 = done_cnt;
    int n = 0;
    while (done_cnt == d0 && n < 200) begin @(negedge clk); #2; n++; end
    chk(tag, done_cnt - d0, 1);
  endtask

  typedef struct { logic [7:0] d; logic [5:0] r; } vec_t;
  vec_t tbl[12];
  logic [11:0] wrap_tbl[4];

  task automatic check_seq(string tag);
    chk({tag, "_count"}, dq.size(), 12);
    for (int i = 0; i < 12 && i < dq.size(); i++) begin
      chk({tag, "_data"}, dq[i], tbl[i].d);
      chk({tag, "_row"}, rq[i], tbl[i].r);
    end
  endtask

  initial begin
    tbl = '{'{8'h10, 0}, '{8'h11, 0}, '{8'h12, 0}, '{8'h13, 0},
            '{8'h30, 1}, '{8'h31, 1}, '{8'h32, 1}, '{8'h33, 1},
            '{8'h50, 2}, '{8'h51, 2}, '{8'h52, 2}, '{8'h53, 2}};
    wrap_tbl = '{12'hFFE, 12'hFFF, 12'h000, 12'h001};

    repeat (3) @(negedge clk);
    #1 chk("reset_outputs", int'({mem_rd, Vin, busy, done, InData, modAddr_IN, filterSel_1,
                                 filterSel_2, horVer, ME_MCBi, mem_addr}), 0);
    @(negedge clk); reset = 0;

    // abort mid-block
    start_blk(12'h100, 12'h010, 3, 3, 1, 1, 5, 6);
    repeat (5) @(negedge clk);
    #1 chk("pre_abort_busy", busy, 1);
    chk("pre_abort_fsel1", filterSel_1, 5);
    reset = 1;
    #1 chk("abort_outputs", int'({mem_rd, Vin, busy, done, InData, modAddr_IN, filterSel_1,
                                 filterSel_2, horVer, ME_MCBi, mem_addr}), 0);
    begin
      int d0 = done_cnt;
      @(negedge clk); reset = 0;
      repeat (20) @(negedge clk);
      #2 chk("abort_no_done", done_cnt - d0, 0);
    end

    // nominal 4x3 block
    clear_q();
    start_blk(12'h010, 12'h020, 3, 2, 0, 1, 3, 4);
    #2 chk("busy_after_start", busy, 1);
    wait_done("nominal_done");
    check_seq("nominal");
    if (cq.size() == 12) begin
      chk("first_vin_latency", cq[0] - s, 3);
      for (int i = 1; i < 12; i++) chk("vin_consecutive", cq[i] - cq[i-1], 1);
      chk("done_after_last_vin", done_cyc - cq[11], 1);
    end
    chk("busy_low_in_done", done_busy, 0);

    // hold for 5 cycles in the middle of row 1
    clear_q();
    start_blk(12'h010, 12'h020, 3, 2, 0, 0, 1, 1);
    repeat (5) @(negedge clk);
    hold = 1;
    begin
      int cnt = 0;
      repeat (5) begin @(negedge clk); #2 cnt += int'(Vin); end
      hold = 0;
      chk("vin_during_hold_le2", int'(cnt <= 2), 1);
    end
    wait_done("hold_done");
    check_seq("hold");

    // address wrap
    clear_q();
    start_blk(12'hFFE, 12'h004, 3, 0, 0, 0, 0, 0);
    wait_done("wrap_done");
    chk("wrap_count", aq.size(), 4);
    for (int i = 0; i < 4 && i < aq.size(); i++) chk("wrap_addr", aq[i], wrap_tbl[i]);

    // 1x1 block, controls held, start while busy ignored
    clear_q();
    start_blk(12'h123, 12'h001, 0, 0, 1, 0, 5, 2);
    #2 chk("one_busy", busy, 1);
    chk("one_fsel1", filterSel_1, 5);
    @(negedge clk);
    cfg_fsel1 = 1; cfg_fsel2 = 7; cfg_horVer = 0; start = 1;
    @(negedge clk);
    start = 0;
    wait_done("one_done");
    chk("one_vin_count", dq.size(), 1);
    if (dq.size() > 0) chk("one_data", dq[0], 8'h23);
    repeat (6) @(negedge clk);
    #2 chk("one_idle_after", busy, 0);
    chk("one_vin_total", dq.size(), 1);
    chk("one_ctrl_held", int'({horVer, ME_MCBi, filterSel_1, filterSel_2}), int'({1'b1, 1'b0, 3'd5, 3'd2}));
    start_blk(12'h000, 12'h001, 0, 0, 0, 1, 3, 6);
    #2 chk("new_ctrl", int'({horVer, ME_MCBi, filterSel_1, filterSel_2}), int'({1'b0, 1'b1, 3'd3, 3'd6}));
    wait_done("new_done");

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end
endmodule
